// File: rtl/rom_dbg_pkg.sv
// Shared definitions for the ROM debug path (UART loader and read-back dump).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_dbg_pkg;

    // Dump engine states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4,
        DONE    = 3'd5
    } dump_state_e;

    // Byte order is MSB first and the address steps by one word, identical to the loader,
    // so a host can diff the dump against the image it downloaded.
    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] ADDR_STEP      = 32'd4;

endpackage

// File: rtl/word_serializer.sv
// Splits a 32-bit word into 4 bytes, MSB first; byte_o is always the byte to send next.
// Latency: load and shift take effect on the next clk edge.
// Backpressure: none internally; the owner shifts only when the current byte is consumed.
// Ports: clk/rst_n, load_i+data_i (load word, index=0), shift_i (advance one byte),
//        byte_o (current byte), last_o (current byte is the final one of the word).
module word_serializer
    import rom_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        shift_i,
    output logic [7:0]  byte_o,
    output logic        last_o
);

    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load_i) begin
            shreg_d = data_i;
            idx_d   = 2'd0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[23:0], 8'h00};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_o = shreg_q[31:24];
    assign last_o = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/rdrom_dump.sv
// Debug read-back: reads N_WORDS ROM words from address 0 and streams them MSB first to uart_tx.
// Latency: r_req 1 cycle after start; first tx_start RD_LAT+1 cycles after r_req; next byte 1 cycle after Tx_done.
// Backpressure: one byte in flight; waits for Tx_done before the next byte; debug_en_i low aborts to IDLE.
// Ports: clk, rst (async active-low), debug_en_i/start_i (control), r_req/r_addr/r_data (ROM read port),
//        tx_start/tx_data/Tx_done (uart_tx handshake), busy_o/dumpdone (status).
module rdrom_dump
    import rom_dbg_pkg::*;
#(
    parameter int N_WORDS = 256,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        debug_en_i,
    input  logic        start_i,
    input  logic [31:0] r_data,
    input  logic        Tx_done,
    output logic        r_req,
    output logic [31:0] r_addr,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy_o,
    output logic        dumpdone
);

    localparam logic [29:0] LAST_WORD = 30'(N_WORDS - 1);
    localparam logic [2:0]  LAT_INIT  = 3'(RD_LAT);

    dump_state_e state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [29:0] word_q, word_d;
    logic [2:0]  lat_q, lat_d;
    logic        busy_q, busy_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic        ser_load, ser_shift, ser_last;
    logic [7:0]  ser_byte;

    word_serializer u_ser (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (ser_load),
        .data_i  (r_data),
        .shift_i (ser_shift),
        .byte_o  (ser_byte),
        .last_o  (ser_last)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        word_d    = word_q;
        lat_d     = lat_q;
        busy_d    = busy_q;
        tx_data_d = tx_data_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && debug_en_i) begin
                    state_d = RD_REQ;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    word_d  = '0;
                end
            end
            RD_REQ: begin
                lat_d   = LAT_INIT;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Counter reaching 1 marks the cycle RD_LAT after r_req: r_data is valid now.
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    ser_load = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                tx_data_d = ser_byte;
                state_d   = WAIT_TX;
            end
            WAIT_TX: begin
                if (Tx_done) begin
                    ser_shift = 1'b1;
                    if (!ser_last) begin
                        state_d = SEND;
                    end else if (word_q == LAST_WORD) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_STEP;
                        word_d  = word_q + 30'd1;
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything; r_addr and tx_data keep their values.
        if (state_q != IDLE && !debug_en_i) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            ser_load  = 1'b0;
            ser_shift = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            word_q    <= '0;
            lat_q     <= '0;
            busy_q    <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            word_q    <= word_d;
            lat_q     <= lat_d;
            busy_q    <= busy_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Strobes are gated by debug_en_i so an abort silences them in the same cycle.
    assign r_req    = (state_q == RD_REQ) && debug_en_i;
    assign tx_start = (state_q == SEND) && debug_en_i;
    assign dumpdone = (state_q == DONE) && debug_en_i;
    assign busy_o   = busy_q;
    assign r_addr   = addr_q;
    // The byte is presented in the tx_start cycle itself and held from the register afterwards.
    assign tx_data  = (state_q == SEND) ? ser_byte : tx_data_q;

endmodule

// File: tb/tb_rdrom_dump.sv
module tb_rdrom_dump;

    localparam int N_WORDS = 3;
    localparam int RD_LAT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        debug_en_i;
    logic        start_i;
    logic [31:0] r_data = 32'h0;
    logic        Tx_done;
    logic        r_req;
    logic [31:0] r_addr;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy_o;
    logic        dumpdone;

    logic        uart_done = 1'b0;
    logic        spur      = 1'b0;
    assign Tx_done = uart_done | spur;

    always #5 clk = ~clk;

    rdrom_dump #(.N_WORDS(N_WORDS), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .debug_en_i (debug_en_i),
        .start_i    (start_i),
        .r_data     (r_data),
        .Tx_done    (Tx_done),
        .r_req      (r_req),
        .r_addr     (r_addr),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .busy_o     (busy_o),
        .dumpdone   (dumpdone)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: host byte stream -> ROM image (loader rule: MSB first, +4 per word).
    logic [31:0] rom [N_WORDS];
    logic [7:0]  sent[$];
    logic [7:0]  got_bytes[$];
    logic [31:0] got_addrs[$];
    int          due_q[$];
    logic [31:0] due_addr[$];
    int cyc = 0, last_done_cyc = 0, last_req_cyc = 0, bytes_in_word = 0;
    int n_done = 0, n_dumpdone = 0, uart_cnt = 0, uart_dly = 10;

    // Mid-cycle: observe this cycle's outputs, then drive ROM and UART inputs for this cycle.
    always @(negedge clk) begin
        int idx;
        cyc++;
        if (r_req) begin
            if (got_addrs.size() > 0) check_eq("req_after_done", 64'(cyc), 64'(last_done_cyc + 1));
            check_eq("busy_at_req", 64'(busy_o), 64'd1);
            got_addrs.push_back(r_addr);
            last_req_cyc  = cyc;
            bytes_in_word = 0;
            due_q.push_back(cyc + RD_LAT);
            due_addr.push_back(r_addr);
        end
        if (tx_start) begin
            if (bytes_in_word == 0) check_eq("first_byte_lat", 64'(cyc), 64'(last_req_cyc + RD_LAT + 1));
            else                    check_eq("next_byte_lat", 64'(cyc), 64'(last_done_cyc + 1));
            bytes_in_word++;
            got_bytes.push_back(tx_data);
        end
        if (dumpdone) begin
            n_dumpdone++;
            check_eq("dumpdone_lat", 64'(cyc), 64'(last_done_cyc + 1));
        end
        // ROM: data is valid only in the single cycle RD_LAT after the request; garbage otherwise.
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            idx    = int'(due_addr[0] >> 2);
            r_data = (idx < N_WORDS) ? rom[idx] : $urandom;
            void'(due_q.pop_front());
            void'(due_addr.pop_front());
        end else begin
            r_data = $urandom;
        end
        // uart_tx: Tx_done uart_dly cycles after tx_start.
        uart_done = 1'b0;
        if (uart_cnt != 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                uart_done     = 1'b1;
                last_done_cyc = cyc;
                n_done++;
                if (busy_o && got_bytes.size() > 0) check_eq("tx_hold", 64'(tx_data), 64'(got_bytes[$]));
            end
        end
        if (tx_start) uart_cnt = uart_dly;
    end

    task automatic clear_logs();
        got_bytes.delete();
        got_addrs.delete();
        due_q.delete();
        due_addr.delete();
        n_done = 0;
        n_dumpdone = 0;
        bytes_in_word = 0;
    endtask

    task automatic load_image(input bit fixed);
        logic [31:0] fw [3];
        logic [7:0]  b;
        fw[0] = 32'h1234_5678;
        fw[1] = 32'hDEAD_BEEF;
        fw[2] = 32'hA5A5_0F0F;
        sent.delete();
        for (int i = 0; i < 4 * N_WORDS; i++) begin
            b = fixed ? 8'(fw[i / 4] >> (8 * (3 - i % 4))) : 8'($urandom);
            sent.push_back(b);
            rom[i / 4][8 * (3 - i % 4) +: 8] = b;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic wait_dumpdone(input string tag);
        int k;
        k = 0;
        while (n_dumpdone == 0 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (n_dumpdone == 0) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string tag);
        check_eq({tag, "_nbytes"}, 64'(got_bytes.size()), 64'(4 * N_WORDS));
        for (int i = 0; i < got_bytes.size() && i < sent.size(); i++)
            check_eq({tag, "_byte"}, 64'(got_bytes[i]), 64'(sent[i]));
        check_eq({tag, "_nreq"}, 64'(got_addrs.size()), 64'(N_WORDS));
        for (int w = 0; w < got_addrs.size(); w++)
            check_eq({tag, "_addr"}, 64'(got_addrs[w]), 64'(4 * w));
        check_eq({tag, "_ndone"}, 64'(n_dumpdone), 64'd1);
        check_eq({tag, "_busy_after"}, 64'(busy_o), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_r_req"}, 64'(r_req), 64'd0);
        check_eq({tag, "_r_addr"}, 64'(r_addr), 64'd0);
        check_eq({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        check_eq({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, "_dumpdone"}, 64'(dumpdone), 64'd0);
    endtask

    initial begin
        int k;
        rst = 1'b0;
        debug_en_i = 1'b0;
        start_i = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // start with debug disabled is ignored
        clear_logs();
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        check_eq("nodbg_busy", 64'(busy_o), 64'd0);
        check_eq("nodbg_nreq", 64'(got_addrs.size()), 64'd0);
        debug_en_i = 1'b1;

        // known image
        clear_logs();
        load_image(1'b1);
        uart_dly = 10;
        pulse_start();
        wait_dumpdone("basic");
        check_run("basic");

        // random image + spurious Tx_done in RD_WAIT + start while busy
        clear_logs();
        load_image(1'b0);
        uart_dly = $urandom_range(2, 12);
        pulse_start();
        k = 0;
        while (got_addrs.size() == 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1 spur = 1'b1; start_i = 1'b1;
        @(posedge clk); #1 spur = 1'b0; start_i = 1'b0;
        wait_dumpdone("ignored");
        check_run("ignored");

        // abort after the second Tx_done of word 0
        clear_logs();
        load_image(1'b0);
        uart_dly = $urandom_range(2, 12);
        pulse_start();
        k = 0;
        while (n_done < 2 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        debug_en_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_nbytes", 64'(got_bytes.size()), 64'd2);
        check_eq("abort_ndone", 64'(n_dumpdone), 64'd0);
        check_eq("abort_busy", 64'(busy_o), 64'd0);
        check_eq("abort_nreq", 64'(got_addrs.size()), 64'd1);
        debug_en_i = 1'b1;
        clear_logs();
        pulse_start();
        wait_dumpdone("restart");
        check_run("restart");

        // async reset while waiting for Tx_done
        clear_logs();
        load_image(1'b0);
        uart_dly = 10;
        pulse_start();
        k = 0;
        while (got_bytes.size() == 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1 rst = 1'b0;
        #1 check_outputs_zero("midrst");
        #2 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        clear_logs();
        pulse_start();
        wait_dumpdone("after_rst");
        check_run("after_rst");

        // further random round trips
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            load_image(1'b0);
            uart_dly = $urandom_range(2, 12);
            pulse_start();
            wait_dumpdone("rand");
            check_run("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
